// File: rtl/mul_unit_pipe.sv
// -----------------------------------------------------------------------------
// mul_unit_pipe
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) sitting between the
// multiply reservation station and the CDB.
//
// Structure: S0 holds the issued operands, the product is formed from S0,
// optional middle stages carry the selected XLEN result, and a small result
// FIFO buffers completed entries until the CDB grants them. Every stage and
// FIFO slot carries its branch mask and is killed/cleared on branch resolve.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous kill of everything in flight and buffered
//   iss_*             issue handshake (valid/ready), opcode, operands, tags,
//                     branch dependency mask
//   br_valid/mispred/idx  branch resolution broadcast
//   cdb_valid/grant   result handshake towards the CDB
//   cdb_data, cdb_rob_idx, cdb_rd, cdb_pd  result and its tags
// -----------------------------------------------------------------------------
module mul_unit_pipe #(
    parameter int XLEN      = 32,
    parameter int STAGES    = 2,
    parameter int OUT_DEPTH = 2,
    parameter int ROB_BITS  = 5,
    parameter int PREG_BITS = 6,
    parameter int BRU_N     = 4,
    parameter int BRU_BITS  = $clog2(BRU_N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [1:0]           iss_op,
    input  logic [XLEN-1:0]      iss_a,
    input  logic [XLEN-1:0]      iss_b,
    input  logic [ROB_BITS-1:0]  iss_rob_idx,
    input  logic [4:0]           iss_rd,
    input  logic [PREG_BITS-1:0] iss_pd,
    input  logic [BRU_N-1:0]     iss_br_mask,
    input  logic                 br_valid,
    input  logic                 br_mispred,
    input  logic [BRU_BITS-1:0]  br_idx,
    output logic                 cdb_valid,
    input  logic                 cdb_grant,
    output logic [XLEN-1:0]      cdb_data,
    output logic [ROB_BITS-1:0]  cdb_rob_idx,
    output logic [4:0]           cdb_rd,
    output logic [PREG_BITS-1:0] cdb_pd
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // 'live' is the stage valid in the pipeline; in the FIFO a slot that is
    // counted but not live is a dead entry waiting to be popped.
    typedef struct packed {
        logic                 live;
        logic [BRU_N-1:0]     mask;
        logic [ROB_BITS-1:0]  rob_idx;
        logic [4:0]           rd;
        logic [PREG_BITS-1:0] pd;
    } tag_t;

    typedef struct packed {
        tag_t            tag;
        logic [XLEN-1:0] data;
    } res_t;

    // Branch resolve: a mispredict kills dependents, a correct prediction
    // just drops the dependency bit.
    function automatic tag_t br_update(input tag_t t, input logic bv, input logic bm,
                                       input logic [BRU_BITS-1:0] bi);
        tag_t r;
        r = t;
        if (bv && t.mask[bi]) begin
            if (bm) r.live = 1'b0;
            else    r.mask[bi] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------- control
    tag_t             iss_tag;
    tag_t             s0_tag;
    logic [XLEN-1:0]  s0_a;
    logic [XLEN-1:0]  s0_b;
    logic [1:0]       s0_op;
    res_t             s0_res;
    res_t             last_res;
    tag_t             last_tag_upd;

    res_t             fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    res_t             head;

    logic head_present, head_kill, fifo_full, pop, push, adv, accept;

    assign head         = fifo_mem[rd_ptr];
    assign head_present = (fifo_cnt != '0);
    assign head_kill    = br_valid & br_mispred & head.tag.mask[br_idx];
    assign cdb_valid    = head_present & head.tag.live & !head_kill & !flush;
    assign pop          = head_present & (!head.tag.live | (cdb_valid & cdb_grant));
    assign fifo_full    = (fifo_cnt == CNT_W'(OUT_DEPTH));
    assign adv          = !fifo_full | pop;
    assign iss_ready    = adv & !rst;
    assign accept       = iss_valid & iss_ready;

    assign cdb_data     = head.data;
    assign cdb_rob_idx  = head.tag.rob_idx;
    assign cdb_rd       = head.tag.rd;
    assign cdb_pd       = head.tag.pd;

    assign iss_tag = '{live: accept, mask: iss_br_mask, rob_idx: iss_rob_idx,
                       rd: iss_rd, pd: iss_pd};

    // -------------------------------------------------------------- multiply
    // A single (XLEN+1)-bit signed multiply covers all four flavours; the
    // extra bit is the sign or zero extension chosen by the opcode.
    logic                   a_signed, b_signed;
    logic signed [XLEN:0]   a_ext, b_ext;
    logic signed [2*XLEN-1:0] prod;
    logic [XLEN-1:0]        s0_result;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and a latch is inferred.
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (s0_op)
            OP_MUL:    begin a_signed = 1'b0; b_signed = 1'b0; end
            OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_MULHSU: begin a_signed = 1'b1; b_signed = 1'b0; end
            OP_MULHU:  begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
        a_ext     = {a_signed & s0_a[XLEN-1], s0_a};
        b_ext     = {b_signed & s0_b[XLEN-1], s0_b};
        // Low 2*XLEN bits of the product are exact; the top bits are not needed.
        prod      = (2*XLEN)'(a_ext) * (2*XLEN)'(b_ext);
        s0_result = (s0_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign s0_res = '{tag: s0_tag, data: s0_result};

    // -------------------------------------------------------------------- S0
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            s0_tag <= '0;
            s0_a   <= '0;
            s0_b   <= '0;
            s0_op  <= '0;
        end else if (flush) begin
            s0_tag.live <= 1'b0;
        end else if (adv) begin
            // A killed issue still occupies S0, just as a bubble.
            s0_tag <= br_update(iss_tag, br_valid, br_mispred, br_idx);
            s0_a   <= iss_a;
            s0_b   <= iss_b;
            s0_op  <= iss_op;
        end else begin
            s0_tag <= br_update(s0_tag, br_valid, br_mispred, br_idx);
        end
    end

    // ---------------------------------------------------------- middle stages
    generate
        if (STAGES == 2) begin : g_direct
            assign last_res = s0_res;
        end else begin : g_mid
            res_t mid [STAGES-2];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES - 2; i++) mid[i] <= '0;
                end else if (flush) begin
                    for (int i = 0; i < STAGES - 2; i++) mid[i].tag.live <= 1'b0;
                end else if (adv) begin
                    mid[0].tag  <= br_update(s0_res.tag, br_valid, br_mispred, br_idx);
                    mid[0].data <= s0_res.data;
                    for (int i = 1; i < STAGES - 2; i++) begin
                        mid[i].tag  <= br_update(mid[i-1].tag, br_valid, br_mispred, br_idx);
                        mid[i].data <= mid[i-1].data;
                    end
                end else begin
                    for (int i = 0; i < STAGES - 2; i++)
                        mid[i].tag <= br_update(mid[i].tag, br_valid, br_mispred, br_idx);
                end
            end

            assign last_res = mid[STAGES-3];
        end
    endgenerate

    // ------------------------------------------------------------ result FIFO
    // Dead entries leaving the last stage are simply dropped, not pushed.
    assign last_tag_upd = br_update(last_res.tag, br_valid, br_mispred, br_idx);
    assign push         = adv & last_tag_upd.live & !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the FIFO storage is reset too: it is only a few flops and
            // it keeps the cdb_* outputs at zero coming out of reset.
            for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            for (int i = 0; i < OUT_DEPTH; i++)
                fifo_mem[i].tag <= br_update(fifo_mem[i].tag, br_valid, br_mispred, br_idx);
            if (push) begin
                fifo_mem[wr_ptr].tag  <= last_tag_upd;
                fifo_mem[wr_ptr].data <= last_res.data;
                wr_ptr                <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_mul_unit_pipe
// Self-checking bench for mul_unit_pipe: a scoreboard queue tracks every
// accepted live entry (with its branch mask), applies branch kill/clear and
// flush, and compares each CDB result in order. A table of hand-computed
// vectors checks arithmetic and latency; short sequences cover stall,
// branch, flush and asynchronous reset corners; a random phase follows.
// -----------------------------------------------------------------------------
module tb_mul_unit_pipe;

    localparam int XLEN      = 32;
    localparam int STAGES    = 2;
    localparam int OUT_DEPTH = 2;
    localparam int ROB_BITS  = 5;
    localparam int PREG_BITS = 6;
    localparam int BRU_N     = 4;
    localparam int BRU_BITS  = 2;
    localparam int CAP       = STAGES - 1 + OUT_DEPTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [1:0]           iss_op;
    logic [XLEN-1:0]      iss_a;
    logic [XLEN-1:0]      iss_b;
    logic [ROB_BITS-1:0]  iss_rob_idx;
    logic [4:0]           iss_rd;
    logic [PREG_BITS-1:0] iss_pd;
    logic [BRU_N-1:0]     iss_br_mask;
    logic                 br_valid;
    logic                 br_mispred;
    logic [BRU_BITS-1:0]  br_idx;
    logic                 cdb_valid;
    logic                 cdb_grant;
    logic [XLEN-1:0]      cdb_data;
    logic [ROB_BITS-1:0]  cdb_rob_idx;
    logic [4:0]           cdb_rd;
    logic [PREG_BITS-1:0] cdb_pd;

    mul_unit_pipe #(
        .XLEN(XLEN), .STAGES(STAGES), .OUT_DEPTH(OUT_DEPTH),
        .ROB_BITS(ROB_BITS), .PREG_BITS(PREG_BITS), .BRU_N(BRU_N), .BRU_BITS(BRU_BITS)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_a(iss_a), .iss_b(iss_b), .iss_rob_idx(iss_rob_idx), .iss_rd(iss_rd),
        .iss_pd(iss_pd), .iss_br_mask(iss_br_mask),
        .br_valid(br_valid), .br_mispred(br_mispred), .br_idx(br_idx),
        .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_data(cdb_data),
        .cdb_rob_idx(cdb_rob_idx), .cdb_rd(cdb_rd), .cdb_pd(cdb_pd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rob;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [3:0]  mask;
    } sb_t;

    sb_t         sbq[$];
    vec_t        tbl[10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          accepts  = 0;
    int          out_count = 0;
    int          first_out = 0;
    int          last_out  = 0;
    int          tag_ctr   = 0;
    logic [31:0] cur_exp;
    logic        s_ready;
    logic        s_cvalid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference product, computed with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sbv;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (op)
            2'd0:    p = ua * ub;
            2'd1:    p = sa * sbv;
            2'd2:    p = sa * longint'(ub);
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] mask, input logic [31:0] exp);
        iss_valid   = 1'b1;
        iss_op      = op;
        iss_a       = a;
        iss_b       = b;
        iss_br_mask = mask;
        iss_rob_idx = 5'(tag_ctr);
        iss_rd      = 5'(tag_ctr * 7);
        iss_pd      = 6'(tag_ctr + 17);
        cur_exp     = exp;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] mask);
        set_issue(op, a, b, mask, model(op, a, b));
    endtask

    task automatic idle();
        iss_valid  = 1'b0;
        br_valid   = 1'b0;
        br_mispred = 1'b0;
        flush      = 1'b0;
    endtask

    // One clock cycle. Entered at a falling edge with inputs already set;
    // samples #1 later, updates the scoreboard, returns at the next falling edge.
    task automatic step();
        sb_t e;
        #1;
        s_ready  = iss_ready;
        s_cvalid = cdb_valid;
        if (flush) begin
            check("flush_cdb_quiet", {63'b0, cdb_valid}, 64'd0);
            sbq.delete();
        end else begin
            if (br_valid) begin
                sb_t nq[$];
                foreach (sbq[i]) begin
                    sb_t q = sbq[i];
                    if (br_mispred && q.mask[br_idx]) continue;
                    if (!br_mispred) q.mask[br_idx] = 1'b0;
                    nq.push_back(q);
                end
                sbq = nq;
            end
            if (cdb_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_cdb", {63'b0, cdb_valid}, 64'd0);
                end else begin
                    e = sbq[0];
                    check("cdb_result", {16'b0, cdb_data, cdb_rob_idx, cdb_rd, cdb_pd},
                          {16'b0, e.data, e.rob, e.rd, e.pd});
                    if (cdb_grant) begin
                        void'(sbq.pop_front());
                        if (out_count == 0) first_out = cyc;
                        last_out = cyc;
                        out_count++;
                    end
                end
            end
            if (iss_valid && iss_ready) begin
                accepts++;
                e.data = cur_exp;
                e.rob  = iss_rob_idx;
                e.rd   = iss_rd;
                e.pd   = iss_pd;
                e.mask = iss_br_mask;
                tag_ctr++;
                if (br_valid && !br_mispred) e.mask[br_idx] = 1'b0;
                if (!(br_valid && br_mispred && iss_br_mask[br_idx])) sbq.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int max);
        idle();
        cdb_grant = 1'b1;
        for (int k = 0; k < max && sbq.size() != 0; k++) step();
        check("drain_empty", 64'(sbq.size()), 64'd0);
        for (int k = 0; k < 3; k++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[2] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[4] = '{2'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
        tbl[5] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[7] = '{2'd3, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        tbl[8] = '{2'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
        tbl[9] = '{2'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};

        rst = 1'b1;
        idle();
        cdb_grant   = 1'b0;
        iss_op      = '0;
        iss_a       = '0;
        iss_b       = '0;
        iss_br_mask = '0;
        iss_rob_idx = '0;
        iss_rd      = '0;
        iss_pd      = '0;
        br_idx      = '0;
        cur_exp     = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready_low", {63'b0, iss_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_cdb_valid", {63'b0, cdb_valid}, 64'd0);
        check("rst_cdb_fields", {16'b0, cdb_data, cdb_rob_idx, cdb_rd, cdb_pd}, 64'd0);
        check("rst_ready_high", {63'b0, iss_ready}, 64'd1);
        @(negedge clk);

        // Arithmetic table with exact latency
        cdb_grant = 1'b1;
        for (int v = 0; v < 10; v++) begin
            set_issue(tbl[v].op, tbl[v].a, tbl[v].b, 4'b0000, tbl[v].exp);
            step();
            check("tbl_accept", {63'b0, s_ready}, 64'd1);
            idle();
            for (int k = 1; k < STAGES; k++) begin
                step();
                check("lat_early", {63'b0, s_cvalid}, 64'd0);
            end
            step();
            check("lat_due", {63'b0, s_cvalid}, 64'd1);
        end
        drain(10);

        // Back-to-back issue with continuous grant
        out_count = 0;
        cdb_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(2'(i), 32'(i), 32'(i + 3), 4'b0000);
            step();
            check("b2b_ready", {63'b0, s_ready}, 64'd1);
        end
        drain(20);
        check("b2b_count", 64'(out_count), 64'd8);
        check("b2b_consecutive", 64'(last_out - first_out), 64'd7);

        // Capacity with grant held low
        accepts   = 0;
        cdb_grant = 1'b0;
        for (int k = 0; k < 6; k++) begin
            issue(2'd0, 32'(accepts + 1), 32'(accepts + 2), 4'b0000);
            step();
        end
        check("cap_accepts", 64'(accepts), 64'(CAP));
        check("cap_ready_low", {63'b0, s_ready}, 64'd0);
        drain(20);

        // Mispredict kills FIFO head and S0, survivor unaffected
        out_count = 0;
        cdb_grant = 1'b0;
        issue(2'd0, 32'd7, 32'd9, 4'b0010);
        step();
        issue(2'd0, 32'd11, 32'd13, 4'b0000);
        step();
        issue(2'd3, 32'd5, 32'd6, 4'b0010);
        step();
        idle();
        cdb_grant  = 1'b1;
        br_valid   = 1'b1;
        br_mispred = 1'b1;
        br_idx     = 2'd1;
        step();
        check("kill_head_same_cycle", {63'b0, s_cvalid}, 64'd0);
        idle();
        step();
        check("dead_head_silent", {63'b0, s_cvalid}, 64'd0);
        drain(10);
        check("kill_survivors", 64'(out_count), 64'd1);

        // Correct prediction clears the bit, including on the issuing entry
        out_count = 0;
        cdb_grant = 1'b1;
        issue(2'd0, 32'd100, 32'd200, 4'b0100);
        step();
        issue(2'd1, 32'hFFFF_FFF9, 32'd9, 4'b0100);
        br_valid   = 1'b1;
        br_mispred = 1'b0;
        br_idx     = 2'd2;
        step();
        issue(2'd2, 32'hFFFF_FFFD, 32'd5, 4'b0000);
        br_valid   = 1'b1;
        br_mispred = 1'b1;
        br_idx     = 2'd2;
        step();
        drain(10);
        check("clear_all_retire", 64'(out_count), 64'd3);

        // Flush wins over accept and pop
        out_count = 0;
        cdb_grant = 1'b0;
        issue(2'd3, 32'd21, 32'd22, 4'b0000);
        step();
        issue(2'd3, 32'd23, 32'd24, 4'b0000);
        step();
        issue(2'd0, 32'd25, 32'd26, 4'b0000);
        cdb_grant = 1'b1;
        flush     = 1'b1;
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_flush_quiet", {63'b0, s_cvalid}, 64'd0);
        end
        check("flush_no_output", 64'(out_count), 64'd0);

        // Asynchronous reset with a full FIFO
        cdb_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(2'd1, 32'(k + 40), 32'(k + 50), 4'b0000);
            step();
        end
        check("pre_rst_full", {63'b0, s_ready}, 64'd0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        sbq.delete();
        check("async_rst_cdb_low", {63'b0, cdb_valid}, 64'd0);
        check("async_rst_ready_low", {63'b0, iss_ready}, 64'd0);
        check("async_rst_data", {32'b0, cdb_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {63'b0, iss_ready}, 64'd1);
        @(negedge clk);
        cdb_grant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_rst_quiet", {63'b0, s_cvalid}, 64'd0);
        end

        // Random traffic with backpressure, branches and occasional flush
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(9) < 7)
                issue(2'($urandom_range(3)), pick(), pick(),
                      ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'b0000);
            else
                iss_valid = 1'b0;
            cdb_grant  = ($urandom_range(9) < 7);
            br_valid   = ($urandom_range(9) < 2);
            br_mispred = 1'($urandom_range(1));
            br_idx     = 2'($urandom_range(3));
            flush      = ($urandom_range(49) == 0);
            step();
        end
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
